// File: rtl/rv32_pkg.sv
// Shared core constants: LSU access widths, writeback sources, branch conditions, ALU ops.
// Also holds the LSU state encoding and the alignment helper used by the load/store unit.
package rv32_pkg;

    localparam logic [1:0] LSU_W_B   = 2'b00;
    localparam logic [1:0] LSU_W_H   = 2'b01;
    localparam logic [1:0] LSU_W_W   = 2'b10;
    localparam logic [1:0] LSU_W_ILL = 2'b11;
    localparam int         LSU_FUNC_UNSIGNED_BIT = 2;

    localparam logic [1:0] WB_SOURCE_ALU = 2'd0;
    localparam logic [1:0] WB_SOURCE_LSU = 2'd1;
    localparam logic [1:0] WB_SOURCE_PC4 = 2'd2;
    localparam logic [1:0] WB_SOURCE_IMM = 2'd3;

    localparam logic [2:0] BR_COND_NONE = 3'd0;
    localparam logic [2:0] BR_COND_EQ   = 3'd1;
    localparam logic [2:0] BR_COND_NE   = 3'd2;
    localparam logic [2:0] BR_COND_LT   = 3'd3;
    localparam logic [2:0] BR_COND_GE   = 3'd4;
    localparam logic [2:0] BR_COND_LTU  = 3'd5;
    localparam logic [2:0] BR_COND_GEU  = 3'd6;
    localparam logic [2:0] BR_COND_JUMP = 3'd7;

    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_SLL  = 4'd2;
    localparam logic [3:0] ALU_OP_SLT  = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU = 4'd4;
    localparam logic [3:0] ALU_OP_XOR  = 4'd5;
    localparam logic [3:0] ALU_OP_SRL  = 4'd6;
    localparam logic [3:0] ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] ALU_OP_OR   = 4'd8;
    localparam logic [3:0] ALU_OP_AND  = 4'd9;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_t;

    function automatic logic lsu_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        return ((width == LSU_W_H) && addr_lo[0]) || ((width == LSU_W_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/rv32_mod_lsu_align.sv
// Byte-lane mapping for stores and byte/half extraction with sign/zero extension for loads.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Width 11 (illegal) yields zero lanes and zero data; the caller never issues it to the bus.
module rv32_mod_lsu_align
    import rv32_pkg::*;
(
    input  logic [1:0]  width,
    input  logic        load_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'h00;
        case (addr_lo)
            2'd0:    sel_byte = bus_rdata[7:0];
            2'd1:    sel_byte = bus_rdata[15:8];
            2'd2:    sel_byte = bus_rdata[23:16];
            default: sel_byte = bus_rdata[31:24];
        endcase
        sel_half = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    end

    always_comb begin
        be         = 4'b0000;
        lane_wdata = 32'h0;
        load_data  = 32'h0;
        case (width)
            LSU_W_B: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{store_data[7:0]}};
                load_data  = {{24{sel_byte[7] & ~load_unsigned}}, sel_byte};
            end
            LSU_W_H: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                lane_wdata = {2{store_data[15:0]}};
                load_data  = {{16{sel_half[15] & ~load_unsigned}}, sel_half};
            end
            LSU_W_W: begin
                be         = 4'b1111;
                lane_wdata = store_data;
                load_data  = bus_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32_mod_load_store_unit.sv
// Load/store unit: one data-bus access at a time, returns extended load data (optional RV32_LSU_MISALIGN_TRAP_EN).
// Latency: accept at 0, bus_req at 1, bus_ack at N -> resp_valid at N+1; illegal/trapped accesses respond at 1.
// Backpressure: req_ready only in IDLE; bus access ends on bus_ack, bus_err or TIMEOUT_CYCLES without ack.
module rv32_mod_load_store_unit
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [3:0]  req_func,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lat_width;
    logic             lat_unsigned;
    logic [1:0]       lat_addr_lo;

    logic [1:0]  req_width;
    logic [1:0]  eff_addr_lo;
    logic        reject;
    logic        unused_func3;

    logic [1:0]  al_width;
    logic        al_unsigned;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;

    assign req_width    = req_func[1:0];
    assign unused_func3 = req_func[3];

`ifdef RV32_LSU_MISALIGN_TRAP_EN
    assign eff_addr_lo = req_addr[1:0];
    assign reject      = (req_width == LSU_W_ILL) || lsu_misaligned(req_width, req_addr[1:0]);
`else
    // Misaligned halves/words are silently forced onto their natural boundary.
    always_comb begin
        eff_addr_lo = req_addr[1:0];
        if (req_width == LSU_W_H) eff_addr_lo[0] = 1'b0;
        if (req_width == LSU_W_W) eff_addr_lo    = 2'b00;
    end
    assign reject = (req_width == LSU_W_ILL);
`endif

    // The aligner sees the live request while idle and the latched access while on the bus.
    assign al_width    = (state == LSU_IDLE) ? req_width   : lat_width;
    assign al_unsigned = (state == LSU_IDLE) ? req_func[LSU_FUNC_UNSIGNED_BIT] : lat_unsigned;
    assign al_addr_lo  = (state == LSU_IDLE) ? eff_addr_lo : lat_addr_lo;

    rv32_mod_lsu_align u_align (
        .width         (al_width),
        .load_unsigned (al_unsigned),
        .addr_lo       (al_addr_lo),
        .store_data    (req_wdata),
        .bus_rdata     (bus_rdata),
        .be            (al_be),
        .lane_wdata    (al_wdata),
        .load_data     (al_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LSU_IDLE;
            cnt          <= '0;
            lat_width    <= LSU_W_B;
            lat_unsigned <= 1'b0;
            lat_addr_lo  <= 2'b00;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_error   <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'h0;
            bus_be       <= 4'h0;
            bus_wdata    <= 32'h0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        req_ready    <= 1'b0;
                        cnt          <= '0;
                        lat_width    <= req_width;
                        lat_unsigned <= req_func[LSU_FUNC_UNSIGNED_BIT];
                        lat_addr_lo  <= eff_addr_lo;
                        if (reject) begin
                            state      <= LSU_RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state     <= LSU_BUS;
                            bus_req   <= 1'b1;
                            bus_we    <= req_write;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_be    <= al_be;
                            bus_wdata <= al_wdata;
                        end
                    end
                end
                LSU_BUS: begin
                    if (bus_err || bus_ack || (cnt == CNT_LAST)) begin
                        state      <= LSU_RESP;
                        resp_valid <= 1'b1;
                        resp_error <= bus_err || !bus_ack;
                        resp_rdata <= (!bus_err && bus_ack && !bus_we) ? al_load : 32'h0;
                        bus_req    <= 1'b0;
                        bus_we     <= 1'b0;
                        bus_addr   <= 32'h0;
                        bus_be     <= 4'h0;
                        bus_wdata  <= 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= LSU_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    resp_rdata <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mod_load_store_unit.sv
// Directed bench for rv32_mod_load_store_unit with TIMEOUT_CYCLES=4; honours RV32_LSU_MISALIGN_TRAP_EN.
module tb_rv32_mod_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [3:0]  req_func = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_mod_load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_func   (req_func),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_err    (bus_err),
        .bus_rdata  (bus_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single accepting edge; returns one cycle after acceptance.
    task automatic issue(input logic wr, input logic [3:0] func, input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_func  = func;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic ack_with(input logic [31:0] rd);
        bus_ack   = 1'b1;
        bus_rdata = rd;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        rst = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);

        // LB a=0x1003, top byte 0x80 sign-extends
        issue(1'b0, 4'b0000, 32'h0000_1003, 32'h0);
        check("lb_bus_req", 32'(bus_req), 32'd1);
        check("lb_bus_we", 32'(bus_we), 32'd0);
        check("lb_bus_addr", bus_addr, 32'h0000_1000);
        check("lb_bus_be", 32'(bus_be), 32'h8);
        check("lb_req_ready", 32'(req_ready), 32'd0);
        ack_with(32'h80FF_1234);
        check("lb_resp_valid", 32'(resp_valid), 32'd1);
        check("lb_resp_rdata", resp_rdata, 32'hFFFF_FF80);
        check("lb_resp_error", 32'(resp_error), 32'd0);
        check("lb_bus_req_drop", 32'(bus_req), 32'd0);
        tick();
        check("lb_resp_pulse", 32'(resp_valid), 32'd0);
        check("lb_ready_back", 32'(req_ready), 32'd1);

        // LHU a=0x2002
        issue(1'b0, 4'b0101, 32'h0000_2002, 32'h0);
        check("lhu_bus_be", 32'(bus_be), 32'hC);
        ack_with(32'hBEEF_0000);
        check("lhu_resp_rdata", resp_rdata, 32'h0000_BEEF);
        check("lhu_resp_error", 32'(resp_error), 32'd0);
        tick();

        // LH a=0x2002 signed
        issue(1'b0, 4'b0001, 32'h0000_2002, 32'h0);
        ack_with(32'hBEEF_0000);
        check("lh_resp_rdata", resp_rdata, 32'hFFFF_BEEF);
        tick();

        // SW a=0x3000, ack during the third bus cycle
        issue(1'b1, 4'b0010, 32'h0000_3000, 32'hDEAD_BEEF);
        check("sw_bus_we", 32'(bus_we), 32'd1);
        check("sw_bus_be", 32'(bus_be), 32'hF);
        check("sw_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        tick();
        check("sw_ready_c2", 32'(req_ready), 32'd0);
        check("sw_resp_c2", 32'(resp_valid), 32'd0);
        tick();
        check("sw_bus_req_c3", 32'(bus_req), 32'd1);
        check("sw_bus_addr_c3", bus_addr, 32'h0000_3000);
        ack_with(32'hFFFF_FFFF);
        check("sw_resp_valid_c4", 32'(resp_valid), 32'd1);
        check("sw_resp_rdata", resp_rdata, 32'h0);
        check("sw_resp_error", 32'(resp_error), 32'd0);
        tick();

        // SB a=0x4001
        issue(1'b1, 4'b0000, 32'h0000_4001, 32'h0000_0055);
        check("sb_bus_be", 32'(bus_be), 32'h2);
        check("sb_bus_wdata", bus_wdata, 32'h5555_5555);
        ack_with(32'h0);
        check("sb_resp_valid", 32'(resp_valid), 32'd1);
        tick();

        // Illegal width: no bus cycle, immediate error response
        issue(1'b0, 4'b0011, 32'h0000_4000, 32'h0);
        check("ill_bus_req", 32'(bus_req), 32'd0);
        check("ill_resp_valid", 32'(resp_valid), 32'd1);
        check("ill_resp_error", 32'(resp_error), 32'd1);
        tick();
        check("ill_ready_back", 32'(req_ready), 32'd1);

        // Timeout after 4 bus cycles without ack
        issue(1'b0, 4'b0010, 32'h0000_6000, 32'h0);
        tick();
        tick();
        tick();
        check("to_bus_req_c4", 32'(bus_req), 32'd1);
        check("to_resp_c4", 32'(resp_valid), 32'd0);
        tick();
        check("to_bus_req_drop", 32'(bus_req), 32'd0);
        check("to_resp_valid", 32'(resp_valid), 32'd1);
        check("to_resp_error", 32'(resp_error), 32'd1);
        tick();
        ack_with(32'h1234_5678);
        check("late_ack_resp", 32'(resp_valid), 32'd0);
        check("late_ack_ready", 32'(req_ready), 32'd1);

        // bus_ack and bus_err together: error wins
        issue(1'b0, 4'b0010, 32'h0000_7000, 32'h0);
        bus_err = 1'b1;
        ack_with(32'h1234_5678);
        bus_err = 1'b0;
        check("ackerr_resp_valid", 32'(resp_valid), 32'd1);
        check("ackerr_resp_error", 32'(resp_error), 32'd1);
        check("ackerr_resp_rdata", resp_rdata, 32'h0);
        tick();

        // Reset while on the bus aborts silently
        issue(1'b0, 4'b0010, 32'h0000_8000, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstbus_bus_req", 32'(bus_req), 32'd0);
        check("rstbus_req_ready", 32'(req_ready), 32'd1);
        check("rstbus_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        check("rstbus_no_resp", 32'(resp_valid), 32'd0);

        // LW a=0x5002: trapped or forced onto the word boundary
        issue(1'b0, 4'b0010, 32'h0000_5002, 32'h0);
`ifdef RV32_LSU_MISALIGN_TRAP_EN
        check("lwmis_bus_req", 32'(bus_req), 32'd0);
        check("lwmis_resp_valid", 32'(resp_valid), 32'd1);
        check("lwmis_resp_error", 32'(resp_error), 32'd1);
        tick();
`else
        check("lwmis_bus_addr", bus_addr, 32'h0000_5000);
        check("lwmis_bus_be", 32'(bus_be), 32'hF);
        ack_with(32'hCAFE_F00D);
        check("lwmis_resp_rdata", resp_rdata, 32'hCAFE_F00D);
        check("lwmis_resp_error", 32'(resp_error), 32'd0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
